// File: rtl/dll_rx_seq_checker.sv
// dll_rx_seq_checker
//
// Receive-side sequence/LCRC checker and ACK/NAK scheduler for the Data Link
// Layer. Every TLP end is judged against NEXT_RCV_SEQ. The block decides
// whether the TLP goes to the Transaction Layer or is dropped. It keeps the
// NAK_SCHEDULED episode state and the ACK latency timer, and it presents one
// ACK/NAK request at a time to the DLLP generator.
//
// Ports:
//   sclk, srst_n        clock, asynchronous active-low reset
//   DLCM_state_i        DLCMSM state; only DL_ACTIVE_ENC counts as link up
//   tlp_valid_i         one-cycle strobe at TLP end, with:
//     tlp_seq_i           sequence number of the TLP
//     tlp_lcrc_ok_i       1 = LCRC matched
//   tlp_accept_o        registered pulse: TLP forwarded
//   tlp_discard_o       registered pulse: TLP dropped
//   next_rcv_seq_o      current NEXT_RCV_SEQ
//   nak_scheduled_o     current NAK_SCHEDULED
//   dllp_req_valid_o    ACK/NAK request pending
//   dllp_req_is_nak_o   1 = NAK, 0 = ACK
//   dllp_req_seq_o      AckNak_Seq_Num = NEXT_RCV_SEQ - 1 (mod 2^SEQ_BITS)
//   dllp_req_ready_i    generator takes the request this cycle
module dll_rx_seq_checker #(
  parameter int         SEQ_BITS           = 12,
  parameter int         ACK_LATENCY_CYCLES = 17000,
  parameter logic [1:0] DL_ACTIVE_ENC      = 2'b10
) (
  input  logic                sclk,
  input  logic                srst_n,
  input  logic [1:0]          DLCM_state_i,
  input  logic                tlp_valid_i,
  input  logic [SEQ_BITS-1:0] tlp_seq_i,
  input  logic                tlp_lcrc_ok_i,
  output logic                tlp_accept_o,
  output logic                tlp_discard_o,
  output logic [SEQ_BITS-1:0] next_rcv_seq_o,
  output logic                nak_scheduled_o,
  output logic                dllp_req_valid_o,
  output logic                dllp_req_is_nak_o,
  output logic [SEQ_BITS-1:0] dllp_req_seq_o,
  input  logic                dllp_req_ready_i
);

  localparam int                  TMR_W    = $clog2(ACK_LATENCY_CYCLES + 1);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(ACK_LATENCY_CYCLES - 1);
  localparam logic [TMR_W-1:0]    TMR_ONE  = TMR_W'(1);
  localparam logic [SEQ_BITS-1:0] SEQ_ONE  = SEQ_BITS'(1);
  // Half the sequence space: distances 1..SEQ_HALF are duplicates, larger
  // distances mean the TLP is ahead of us (something was lost).
  localparam logic [SEQ_BITS-1:0] SEQ_HALF = {1'b1, {(SEQ_BITS-1){1'b0}}};

  logic [SEQ_BITS-1:0] next_rcv_seq_reg, next_rcv_seq_next;
  logic                nak_scheduled_reg, nak_scheduled_next;
  logic                nak_sent_reg, nak_sent_next;
  logic                ack_pending_reg, ack_pending_next;
  logic                ack_due_reg, ack_due_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic                accept_reg, accept_next;
  logic                discard_reg, discard_next;

  logic                link_active;
  logic                nak_req;
  logic                req_valid;
  logic                xfer;
  logic [SEQ_BITS-1:0] seq_dist;

  assign link_active = (DLCM_state_i == DL_ACTIVE_ENC);
  assign nak_req     = nak_scheduled_reg & ~nak_sent_reg;
  // The NAK term wins automatically: the ACK term is masked by NAK_SCHEDULED.
  assign req_valid   = link_active & (nak_req | (ack_due_reg & ~nak_scheduled_reg));
  assign xfer        = req_valid & dllp_req_ready_i;
  assign seq_dist    = next_rcv_seq_reg - tlp_seq_i;

  always_comb begin
    next_rcv_seq_next  = next_rcv_seq_reg;
    nak_scheduled_next = nak_scheduled_reg;
    nak_sent_next      = nak_sent_reg;
    ack_pending_next   = ack_pending_reg;
    ack_due_next       = ack_due_reg;
    timer_next         = timer_reg;
    accept_next        = 1'b0;
    discard_next       = 1'b0;

    if (!link_active) begin
      next_rcv_seq_next  = '0;
      nak_scheduled_next = 1'b0;
      nak_sent_next      = 1'b0;
      ack_pending_next   = 1'b0;
      ack_due_next       = 1'b0;
      timer_next         = '0;
    end else begin
      // ACK latency timer: runs only while an ACK is owed and no NAK episode
      // is open; further accepted TLPs do not restart it.
      if (ack_pending_reg && !nak_scheduled_reg) begin
        if (timer_reg == TMR_LAST) begin
          ack_due_next = 1'b1;
          timer_next   = '0;
        end else begin
          timer_next = timer_reg + TMR_ONE;
        end
      end

      // Handshake consumes the request that was visible this cycle.
      if (xfer) begin
        if (nak_req) begin
          nak_sent_next = 1'b1;
        end else begin
          ack_due_next     = 1'b0;
          ack_pending_next = 1'b0;
          timer_next       = '0;
        end
      end

      // TLP effects come last so that a set from the TLP beats a clear
      // from a simultaneous handshake.
      if (tlp_valid_i) begin
        if (!tlp_lcrc_ok_i || (seq_dist > SEQ_HALF)) begin
          discard_next = 1'b1;
          if (!nak_scheduled_reg) begin
            nak_scheduled_next = 1'b1;
            nak_sent_next      = 1'b0;
          end
        end else if (seq_dist == '0) begin
          accept_next        = 1'b1;
          next_rcv_seq_next  = next_rcv_seq_reg + SEQ_ONE;
          nak_scheduled_next = 1'b0;
          nak_sent_next      = 1'b0;
          ack_pending_next   = 1'b1;
        end else begin
          // Duplicate: the transmitter missed our ACK, so reissue one now.
          discard_next = 1'b1;
          ack_due_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      next_rcv_seq_reg  <= '0;
      nak_scheduled_reg <= 1'b0;
      nak_sent_reg      <= 1'b0;
      ack_pending_reg   <= 1'b0;
      ack_due_reg       <= 1'b0;
      timer_reg         <= '0;
      accept_reg        <= 1'b0;
      discard_reg       <= 1'b0;
    end else begin
      next_rcv_seq_reg  <= next_rcv_seq_next;
      nak_scheduled_reg <= nak_scheduled_next;
      nak_sent_reg      <= nak_sent_next;
      ack_pending_reg   <= ack_pending_next;
      ack_due_reg       <= ack_due_next;
      timer_reg         <= timer_next;
      accept_reg        <= accept_next;
      discard_reg       <= discard_next;
    end
  end

  assign tlp_accept_o      = accept_reg;
  assign tlp_discard_o     = discard_reg;
  assign next_rcv_seq_o    = next_rcv_seq_reg;
  assign nak_scheduled_o   = nak_scheduled_reg;
  assign dllp_req_valid_o  = req_valid;
  assign dllp_req_is_nak_o = nak_req;
  assign dllp_req_seq_o    = next_rcv_seq_reg - SEQ_ONE;

endmodule

// File: tb/tb_dll_rx_seq_checker.sv
// tb_dll_rx_seq_checker
//
// Directed scenarios plus a randomized run for dll_rx_seq_checker. A
// behavioural model (modulo arithmetic on plain ints) tracks the receiver
// state from the stimulus and provides the expected outputs.
module tb_dll_rx_seq_checker;

  localparam int SB  = 12;
  localparam int MOD = 4096;
  localparam int LAT = 500;

  logic          sclk;
  logic          srst_n;
  logic [1:0]    dlcm;
  logic          tlp_valid;
  logic [SB-1:0] tlp_seq;
  logic          tlp_lcrc_ok;
  logic          tlp_accept;
  logic          tlp_discard;
  logic [SB-1:0] next_rcv_seq;
  logic          nak_scheduled;
  logic          req_valid;
  logic          req_is_nak;
  logic [SB-1:0] req_seq;
  logic          req_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state
  int m_next;
  bit m_nak, m_sent, m_pend, m_due, m_acc, m_dis;
  int m_timer;

  dll_rx_seq_checker #(
    .SEQ_BITS(SB),
    .ACK_LATENCY_CYCLES(LAT),
    .DL_ACTIVE_ENC(2'b10)
  ) dut (
    .sclk(sclk),
    .srst_n(srst_n),
    .DLCM_state_i(dlcm),
    .tlp_valid_i(tlp_valid),
    .tlp_seq_i(tlp_seq),
    .tlp_lcrc_ok_i(tlp_lcrc_ok),
    .tlp_accept_o(tlp_accept),
    .tlp_discard_o(tlp_discard),
    .next_rcv_seq_o(next_rcv_seq),
    .nak_scheduled_o(nak_scheduled),
    .dllp_req_valid_o(req_valid),
    .dllp_req_is_nak_o(req_is_nak),
    .dllp_req_seq_o(req_seq),
    .dllp_req_ready_i(req_ready)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d want end", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_next = 0; m_nak = 0; m_sent = 0; m_pend = 0; m_due = 0; m_timer = 0;
    m_acc = 0; m_dis = 0;
  endtask

  // One clock edge of the receiver, written from the protocol rules.
  task automatic model_edge();
    int d;
    bit nak_out, ack_out;
    bit s_nak, s_sent, s_pend, s_due;
    int s_next, s_timer;
    if (!srst_n || dlcm != 2'b10) begin
      model_clear();
      return;
    end
    nak_out = m_nak && !m_sent;
    ack_out = m_due && !m_nak;
    s_next = m_next; s_nak = m_nak; s_sent = m_sent;
    s_pend = m_pend; s_due = m_due; s_timer = m_timer;
    if (m_pend && !m_nak) begin
      if (m_timer == LAT - 1) begin s_due = 1; s_timer = 0; end
      else s_timer = m_timer + 1;
    end
    if (nak_out && req_ready) s_sent = 1;
    if (ack_out && req_ready) begin s_due = 0; s_pend = 0; s_timer = 0; end
    m_acc = 0; m_dis = 0;
    if (tlp_valid) begin
      d = (m_next - int'(tlp_seq) + MOD) % MOD;
      if (!tlp_lcrc_ok || d > MOD / 2) begin
        m_dis = 1;
        if (!m_nak) begin s_nak = 1; s_sent = 0; end
      end else if (d == 0) begin
        m_acc = 1; s_next = (m_next + 1) % MOD; s_nak = 0; s_sent = 0; s_pend = 1;
      end else begin
        m_dis = 1; s_due = 1;
      end
    end
    m_next = s_next; m_nak = s_nak; m_sent = s_sent;
    m_pend = s_pend; m_due = s_due; m_timer = s_timer;
  endtask

  task automatic tick();
    model_edge();
    @(posedge sclk);
    #1;
    cyc++;
  endtask

  task automatic send_tlp(input int seq, input bit ok);
    tlp_valid = 1'b1;
    tlp_seq = SB'(seq);
    tlp_lcrc_ok = ok;
    tick();
    tlp_valid = 1'b0;
  endtask

  task automatic relink();
    dlcm = 2'b00;
    tick();
    dlcm = 2'b10;
  endtask

  task automatic wait_req(input int bound, output int waited);
    waited = 0;
    while (!req_valid && waited < bound) begin
      tick();
      waited++;
    end
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    dlcm = 2'b10;
    repeat (3) tick();
    checks++; if (tlp_accept !== 1'b0) begin errors++; $display("FAIL reset_accept got %b want 0", tlp_accept); end
    checks++; if (tlp_discard !== 1'b0) begin errors++; $display("FAIL reset_discard got %b want 0", tlp_discard); end
    checks++; if (next_rcv_seq !== 12'd0) begin errors++; $display("FAIL reset_next got %0d want 0", next_rcv_seq); end
    checks++; if (nak_scheduled !== 1'b0) begin errors++; $display("FAIL reset_nak got %b want 0", nak_scheduled); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", req_valid); end
    checks++; if (req_is_nak !== 1'b0) begin errors++; $display("FAIL reset_is_nak got %b want 0", req_is_nak); end
    checks++; if (req_seq !== 12'hFFF) begin errors++; $display("FAIL reset_seq got %h want fff", req_seq); end
    srst_n = 1'b1;
    tick();
    checks++; if (next_rcv_seq !== 12'd0) begin errors++; $display("FAIL reset_release_next got %0d want 0", next_rcv_seq); end
  endtask

  task automatic test_in_order();
    int e0, waited, extra;
    relink();
    req_ready = 1'b1;
    send_tlp(0, 1);
    e0 = cyc;
    checks++; if (tlp_accept !== 1'b1) begin errors++; $display("FAIL inorder_acc0 got %b want 1", tlp_accept); end
    checks++; if (tlp_discard !== 1'b0) begin errors++; $display("FAIL inorder_dis0 got %b want 0", tlp_discard); end
    send_tlp(1, 1);
    checks++; if (tlp_accept !== 1'b1) begin errors++; $display("FAIL inorder_acc1 got %b want 1", tlp_accept); end
    send_tlp(2, 1);
    checks++; if (tlp_accept !== 1'b1) begin errors++; $display("FAIL inorder_acc2 got %b want 1", tlp_accept); end
    checks++; if (next_rcv_seq !== 12'd3) begin errors++; $display("FAIL inorder_next got %0d want 3", next_rcv_seq); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL inorder_early_ack got %b want 0", req_valid); end
    wait_req(LAT + 20, waited);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL inorder_ack_timeout got %b want 1", req_valid); end
    checks++; if (cyc - e0 !== LAT) begin errors++; $display("FAIL inorder_latency got %0d want %0d", cyc - e0, LAT); end
    checks++; if (req_seq !== 12'd2) begin errors++; $display("FAIL inorder_ack_seq got %0d want 2", req_seq); end
    checks++; if (req_is_nak !== 1'b0) begin errors++; $display("FAIL inorder_ack_type got %b want 0", req_is_nak); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL inorder_ack_consumed got %b want 0", req_valid); end
    extra = 0;
    repeat (LAT + 10) begin tick(); if (req_valid) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL inorder_single_ack got %0d extra want 0", extra); end
  endtask

  task automatic test_nak();
    int ea, waited, seen;
    relink();
    req_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_tlp(i, 1);
    send_tlp(5, 0);
    checks++; if (tlp_discard !== 1'b1 || tlp_accept !== 1'b0) begin errors++; $display("FAIL nak_bad_discard got acc=%b dis=%b want acc=0 dis=1", tlp_accept, tlp_discard); end
    checks++; if (nak_scheduled !== 1'b1) begin errors++; $display("FAIL nak_sched got %b want 1", nak_scheduled); end
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b1) begin errors++; $display("FAIL nak_req got v=%b nak=%b want v=1 nak=1", req_valid, req_is_nak); end
    checks++; if (req_seq !== 12'd4) begin errors++; $display("FAIL nak_seq got %0d want 4", req_seq); end
    send_tlp(6, 1);
    checks++; if (tlp_discard !== 1'b1) begin errors++; $display("FAIL nak_ooo_discard got %b want 1", tlp_discard); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL nak_after_send got %b want 0", req_valid); end
    checks++; if (nak_scheduled !== 1'b1 || next_rcv_seq !== 12'd5) begin errors++; $display("FAIL nak_hold got sched=%b next=%0d want sched=1 next=5", nak_scheduled, next_rcv_seq); end
    send_tlp(7, 0);
    seen = 0;
    repeat (10) begin tick(); if (req_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL nak_second got %0d requests want 0", seen); end
    send_tlp(5, 1);
    ea = cyc;
    checks++; if (tlp_accept !== 1'b1) begin errors++; $display("FAIL nak_retry_accept got %b want 1", tlp_accept); end
    checks++; if (nak_scheduled !== 1'b0 || next_rcv_seq !== 12'd6) begin errors++; $display("FAIL nak_clear got sched=%b next=%0d want sched=0 next=6", nak_scheduled, next_rcv_seq); end
    wait_req(LAT + 20, waited);
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b0 || req_seq !== 12'd5) begin errors++; $display("FAIL nak_final_ack got v=%b nak=%b seq=%0d want v=1 nak=0 seq=5", req_valid, req_is_nak, req_seq); end
    // Timer counted 5 edges before the NAK froze it, then resumed.
    checks++; if (cyc - ea !== LAT - 5) begin errors++; $display("FAIL nak_ack_latency got %0d want %0d", cyc - ea, LAT - 5); end
    tick();
  endtask

  task automatic test_duplicate();
    relink();
    req_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_tlp(i, 1);
    send_tlp(10, 1);
    checks++; if (tlp_discard !== 1'b1 || tlp_accept !== 1'b0) begin errors++; $display("FAIL dup_discard got acc=%b dis=%b want acc=0 dis=1", tlp_accept, tlp_discard); end
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b0 || req_seq !== 12'd11) begin errors++; $display("FAIL dup_ack got v=%b nak=%b seq=%0d want v=1 nak=0 seq=11", req_valid, req_is_nak, req_seq); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL dup_consumed got %b want 0", req_valid); end
    send_tlp(12 + MOD - 2048, 1);   // distance exactly 2048: still a duplicate
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b0 || nak_scheduled !== 1'b0) begin errors++; $display("FAIL dup_edge_2048 got v=%b nak=%b sched=%b want v=1 nak=0 sched=0", req_valid, req_is_nak, nak_scheduled); end
    tick();
    send_tlp(12 + MOD - 2049, 1);   // distance 2049: ahead, so NAK
    checks++; if (nak_scheduled !== 1'b1 || req_is_nak !== 1'b1) begin errors++; $display("FAIL dup_edge_2049 got sched=%b nak=%b want sched=1 nak=1", nak_scheduled, req_is_nak); end
    tick();
  endtask

  task automatic test_wrap();
    int waited;
    relink();
    req_ready = 1'b1;
    for (int i = 0; i < 4095; i++) send_tlp(i, 1);
    checks++; if (next_rcv_seq !== 12'd4095) begin errors++; $display("FAIL wrap_pre got %0d want 4095", next_rcv_seq); end
    send_tlp(4095, 1);
    checks++; if (tlp_accept !== 1'b1 || next_rcv_seq !== 12'd0) begin errors++; $display("FAIL wrap_next got acc=%b next=%0d want acc=1 next=0", tlp_accept, next_rcv_seq); end
    wait_req(LAT + 5, waited);
    checks++; if (req_valid !== 1'b1 || req_seq !== 12'd4095) begin errors++; $display("FAIL wrap_ack got v=%b seq=%0d want v=1 seq=4095", req_valid, req_seq); end
    tick();
    send_tlp(0, 1);
    checks++; if (next_rcv_seq !== 12'd1) begin errors++; $display("FAIL wrap_next2 got %0d want 1", next_rcv_seq); end
    wait_req(LAT + 5, waited);
    checks++; if (req_valid !== 1'b1 || req_seq !== 12'd0) begin errors++; $display("FAIL wrap_ack0 got v=%b seq=%0d want v=1 seq=0", req_valid, req_seq); end
    tick();
  endtask

  task automatic test_ready_hold();
    int waited;
    relink();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_tlp(i, 1);
    wait_req(LAT + 5, waited);
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b0 || req_seq !== 12'd2) begin errors++; $display("FAIL hold_ack got v=%b nak=%b seq=%0d want v=1 nak=0 seq=2", req_valid, req_is_nak, req_seq); end
    send_tlp(9, 1);
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b1 || req_seq !== 12'd2) begin errors++; $display("FAIL hold_nak got v=%b nak=%b seq=%0d want v=1 nak=1 seq=2", req_valid, req_is_nak, req_seq); end
    repeat (5) tick();
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b1) begin errors++; $display("FAIL hold_nak_stays got v=%b nak=%b want v=1 nak=1", req_valid, req_is_nak); end
    send_tlp(3, 1);
    checks++; if (req_valid !== 1'b1 || req_is_nak !== 1'b0 || req_seq !== 12'd3) begin errors++; $display("FAIL hold_switch got v=%b nak=%b seq=%0d want v=1 nak=0 seq=3", req_valid, req_is_nak, req_seq); end
    repeat (12) tick();
    checks++; if (req_valid !== 1'b1 || req_seq !== 12'd3) begin errors++; $display("FAIL hold_ack_stays got v=%b seq=%0d want v=1 seq=3", req_valid, req_seq); end
    req_ready = 1'b1;
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hold_consumed got %b want 0", req_valid); end
  endtask

  task automatic test_link_down();
    relink();
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_tlp(i, 1);
    send_tlp(7, 0);
    repeat (3) tick();
    dlcm = 2'b01;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL linkdown_valid_comb got %b want 0", req_valid); end
    tick();
    checks++; if (next_rcv_seq !== 12'd0 || nak_scheduled !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL linkdown_state got next=%0d sched=%b v=%b want 0 0 0", next_rcv_seq, nak_scheduled, req_valid); end
    checks++; if (req_seq !== 12'hFFF) begin errors++; $display("FAIL linkdown_seq got %h want fff", req_seq); end
    dlcm = 2'b10;
    for (int i = 0; i < 3; i++) send_tlp(i, 1);
    send_tlp(8, 1);
    checks++; if (req_valid !== 1'b1 || next_rcv_seq !== 12'd3) begin errors++; $display("FAIL areset_pre got v=%b next=%0d want v=1 next=3", req_valid, next_rcv_seq); end
    #3;
    srst_n = 1'b0;
    #1;
    model_clear();
    checks++; if (next_rcv_seq !== 12'd0 || nak_scheduled !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL areset_state got next=%0d sched=%b v=%b want 0 0 0", next_rcv_seq, nak_scheduled, req_valid); end
    checks++; if (req_seq !== 12'hFFF || tlp_discard !== 1'b0) begin errors++; $display("FAIL areset_out got seq=%h dis=%b want fff 0", req_seq, tlp_discard); end
    tick();
    srst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int r, off;
    relink();
    for (int n = 0; n < 3000; n++) begin
      req_ready = 1'($urandom % 2);
      dlcm = ($urandom % 300 == 0) ? (($urandom % 2) ? 2'b00 : 2'b11) : 2'b10;
      tlp_valid = 1'($urandom % 2);
      tlp_lcrc_ok = ($urandom % 10) != 0;
      r = $urandom % 8;
      case (r)
        4: off = MOD - 1 - int'($urandom % 4);
        5: off = 1 + int'($urandom % 4);
        6: off = int'($urandom % MOD);
        7: off = ($urandom % 2) ? MOD - 2048 : MOD - 2049;
        default: off = 0;
      endcase
      tlp_seq = SB'((m_next + off) % MOD);
      tick();
      tlp_valid = 1'b0;
      dlcm = 2'b10;
      #1;
      checks++; if (tlp_accept !== m_acc) begin errors++; $display("FAIL rnd_accept cyc=%0d got %b want %b", cyc, tlp_accept, m_acc); end
      checks++; if (tlp_discard !== m_dis) begin errors++; $display("FAIL rnd_discard cyc=%0d got %b want %b", cyc, tlp_discard, m_dis); end
      checks++; if (next_rcv_seq !== SB'(m_next)) begin errors++; $display("FAIL rnd_next cyc=%0d got %0d want %0d", cyc, next_rcv_seq, m_next); end
      checks++; if (nak_scheduled !== m_nak) begin errors++; $display("FAIL rnd_nak_sched cyc=%0d got %b want %b", cyc, nak_scheduled, m_nak); end
      checks++; if (req_valid !== ((m_nak && !m_sent) || (m_due && !m_nak))) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, req_valid, (m_nak && !m_sent) || (m_due && !m_nak)); end
      checks++; if (req_is_nak !== (m_nak && !m_sent)) begin errors++; $display("FAIL rnd_is_nak cyc=%0d got %b want %b", cyc, req_is_nak, m_nak && !m_sent); end
      checks++; if (req_seq !== SB'((m_next + MOD - 1) % MOD)) begin errors++; $display("FAIL rnd_seq cyc=%0d got %0d want %0d", cyc, req_seq, (m_next + MOD - 1) % MOD); end
    end
  endtask

  initial begin
    srst_n = 1'b0;
    dlcm = 2'b00;
    tlp_valid = 1'b0;
    tlp_seq = '0;
    tlp_lcrc_ok = 1'b0;
    req_ready = 1'b0;
    model_clear();
    test_reset();
    test_in_order();
    test_nak();
    test_duplicate();
    test_wrap();
    test_ready_hold();
    test_link_down();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
